// File: rtl/conv_ctrl_pkg.sv
// Shared constants for the convolution command controller: widths, opcodes,
// state encoding and the command/status word bit positions.
package conv_ctrl_pkg;

  localparam int unsigned NB_GPIO  = 32;
  localparam int unsigned NB_DATA  = 8;
  localparam int unsigned NB_IMAGE = 10;
  localparam int unsigned NB_STEP  = 16;
  localparam int unsigned NB_BLK   = 4;
  localparam int unsigned NB_OP    = 3;
  localparam int unsigned NB_STATE = 2;

  // Command word layout
  localparam int unsigned CMD_TOGGLE_BIT = 31;
  localparam int unsigned CMD_OP_MSB     = 30;
  localparam int unsigned CMD_OP_LSB     = 28;

  // Status word layout
  localparam int unsigned ST_ACK_BIT    = 31;
  localparam int unsigned ST_STATE_MSB  = 30;
  localparam int unsigned ST_STATE_LSB  = 29;
  localparam int unsigned ST_ERR_BIT    = 28;
  localparam int unsigned ST_BLK_MSB    = 27;
  localparam int unsigned ST_BLK_LSB    = 24;
  localparam int unsigned ST_PAD_WIDTH  = ST_BLK_LSB - NB_STEP;

  // Opcodes
  localparam logic [NB_OP-1:0] OP_NOP       = 3'd0;
  localparam logic [NB_OP-1:0] OP_SOFT_RST  = 3'd1;
  localparam logic [NB_OP-1:0] OP_SET_LEN   = 3'd2;
  localparam logic [NB_OP-1:0] OP_LOAD_DATA = 3'd3;
  localparam logic [NB_OP-1:0] OP_END_LOAD  = 3'd4;
  localparam logic [NB_OP-1:0] OP_START     = 3'd5;
  localparam logic [NB_OP-1:0] OP_STEP      = 3'd6;
  localparam logic [NB_OP-1:0] OP_CLR_ERR   = 3'd7;

  // Controller states
  localparam logic [NB_STATE-1:0] S_IDLE = 2'd0;
  localparam logic [NB_STATE-1:0] S_LOAD = 2'd1;
  localparam logic [NB_STATE-1:0] S_RUN  = 2'd2;
  localparam logic [NB_STATE-1:0] S_DONE = 2'd3;

  // Assemble the host-visible status word
  function automatic logic [NB_GPIO-1:0] pack_status(
    input logic                ack,
    input logic [NB_STATE-1:0] state,
    input logic                err,
    input logic [NB_BLK-1:0]   blk,
    input logic [NB_STEP-1:0]  step
  );
    return {ack, state, err, blk, {ST_PAD_WIDTH{1'b0}}, step};
  endfunction

endpackage

// File: rtl/conv_cmd_ctrl_toggle_detect.sv
// Registers the host command fields and raises a one-cycle new-command strobe
// when the registered toggle disagrees with the controller's ack.
module cmd_toggle_detect
  import conv_ctrl_pkg::*;
(
  input  logic                i_CLK,
  input  logic                i_reset,
  input  logic                i_toggle,
  input  logic [NB_OP-1:0]    i_opcode,
  input  logic [NB_IMAGE-1:0] i_payload,
  input  logic                i_ack,
  output logic [NB_OP-1:0]    o_opcode,
  output logic [NB_IMAGE-1:0] o_payload,
  output logic                o_new
);

  logic                toggle_q;
  logic [NB_OP-1:0]    opcode_q;
  logic [NB_IMAGE-1:0] payload_q;
  logic                new_q;
  logic                new_d;

  // The strobe is suppressed for the cycle after it fires, because ack only
  // flips on the edge that ends the decode cycle.
  always_comb begin
    new_d = (toggle_q != i_ack) && !new_q;
  end

  // Input register and strobe register
  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      toggle_q  <= 1'b0;
      opcode_q  <= '0;
      payload_q <= '0;
      new_q     <= 1'b0;
    end else begin
      toggle_q  <= i_toggle;
      opcode_q  <= i_opcode;
      payload_q <= i_payload;
      new_q     <= new_d;
    end
  end

  assign o_opcode  = opcode_q;
  assign o_payload = payload_q;
  assign o_new     = new_q;

endmodule

// File: rtl/conv_cmd_ctrl.sv
// Host command controller for the convolution address FSM: decodes toggled
// GPIO commands into load/SoP/valid/length controls and reports status.
module conv_cmd_ctrl
  import conv_ctrl_pkg::*;
(
  input  logic                i_CLK,
  input  logic                i_reset,
  input  logic [NB_GPIO-1:0]  i_gpio_cmd,
  output logic [NB_GPIO-1:0]  o_gpio_status,
  output logic                o_load,
  output logic                o_SoP,
  output logic                o_valid,
  output logic [NB_DATA-1:0]  o_data,
  output logic [NB_IMAGE-1:0] o_imgLength,
  input  logic                i_EoP,
  input  logic                i_changeBlock
);

  logic [NB_OP-1:0]    cmd_op;
  logic [NB_IMAGE-1:0] cmd_pay;
  logic                cmd_new;
  logic                unused_cmd_bits;

  logic [NB_STATE-1:0] state_q, state_d;
  logic                ack_q,   ack_d;
  logic                err_q,   err_d;
  logic                load_q,  load_d;
  logic                valid_q, valid_d;
  logic                sop_q,   sop_d;
  logic [NB_DATA-1:0]  data_q,  data_d;
  logic [NB_IMAGE-1:0] len_q,   len_d;
  logic [NB_STEP-1:0]  step_q,  step_d;
  logic [NB_BLK-1:0]   blk_q,   blk_d;

  assign unused_cmd_bits = ^i_gpio_cmd[CMD_OP_LSB-1:NB_IMAGE];

  cmd_toggle_detect u_detect (
    .i_CLK     (i_CLK),
    .i_reset   (i_reset),
    .i_toggle  (i_gpio_cmd[CMD_TOGGLE_BIT]),
    .i_opcode  (i_gpio_cmd[CMD_OP_MSB:CMD_OP_LSB]),
    .i_payload (i_gpio_cmd[NB_IMAGE-1:0]),
    .i_ack     (ack_q),
    .o_opcode  (cmd_op),
    .o_payload (cmd_pay),
    .o_new     (cmd_new)
  );

  // Next-state: Fsmv events first, then the decoded command (SOFT_RST wins)
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_d   = err_q;
    load_d  = load_q;
    valid_d = 1'b0;
    sop_d   = 1'b0;
    data_d  = data_q;
    len_d   = len_q;
    step_d  = step_q;
    blk_d   = blk_q;

    if (state_q == S_RUN) begin
      if (i_changeBlock) blk_d = NB_BLK'(blk_q + 1'b1);
      if (i_EoP)         state_d = S_DONE;
    end

    if (cmd_new) begin
      ack_d = ~ack_q;
      case (cmd_op)
        OP_NOP: ;
        OP_SOFT_RST: begin
          state_d = S_IDLE;
          load_d  = 1'b0;
          step_d  = '0;
          blk_d   = '0;
        end
        OP_SET_LEN: begin
          if ((state_q == S_IDLE || state_q == S_DONE) && cmd_pay != '0)
            len_d = cmd_pay;
          else
            err_d = 1'b1;
        end
        OP_LOAD_DATA: begin
          if (state_q != S_RUN) begin
            state_d = S_LOAD;
            load_d  = 1'b1;
            data_d  = cmd_pay[NB_DATA-1:0];
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_END_LOAD: begin
          if (state_q == S_LOAD) begin
            state_d = S_IDLE;
            load_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_START: begin
          if ((state_q == S_IDLE || state_q == S_DONE) && len_q != '0) begin
            state_d = S_RUN;
            sop_d   = 1'b1;
            step_d  = '0;
            blk_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_STEP: begin
          if (state_q == S_RUN) begin
            valid_d = 1'b1;
            step_d  = NB_STEP'(step_q + 1'b1);
          end else begin
            err_d = 1'b1;
          end
        end
        OP_CLR_ERR: err_d = 1'b0;
        default:    err_d = 1'b1;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      data_q  <= '0;
      len_q   <= '0;
      step_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      load_q  <= load_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      data_q  <= data_d;
      len_q   <= len_d;
      step_q  <= step_d;
      blk_q   <= blk_d;
    end
  end

  assign o_gpio_status = pack_status(ack_q, state_q, err_q, blk_q, step_q);
  assign o_load        = load_q;
  assign o_SoP         = sop_q;
  assign o_valid       = valid_q;
  assign o_data        = data_q;
  assign o_imgLength   = len_q;

endmodule
